// File: rtl/rbm_gibbs_sequencer.sv
// Gibbs-chain controller that time-shares one RBM layer engine for CD-k training.
// Optional per-pass watchdog enabled by defining GIBBS_WATCHDOG_EN.
module rbm_gibbs_sequencer #(
    parameter int unsigned VIS_DIM = 15,
    parameter int unsigned HID_DIM = 5,
    parameter int unsigned MAX_DIM = 15,
    parameter int unsigned STEP_W  = 8,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [STEP_W-1:0]  num_steps,
    input  logic               abort,
    input  logic [VIS_DIM-1:0] vis_in,
    output logic               eng_reset,
    output logic               eng_dir,
    output logic               eng_valid,
    output logic [MAX_DIM-1:0] eng_in,
    input  logic               eng_finish,
    input  logic [MAX_DIM-1:0] eng_result,
    output logic [HID_DIM-1:0] h0_out,
    output logic [VIS_DIM-1:0] vk_out,
    output logic [HID_DIM-1:0] hk_out,
    output logic [STEP_W-1:0]  step_count,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int unsigned USED_DIM = (VIS_DIM > HID_DIM) ? VIS_DIM : HID_DIM;

    typedef enum logic [2:0] {
        StIdle,
        StClrVh,
        StRunVh,
        StClrHv,
        StRunHv,
        StFin
    } state_e;

    state_e               state_q, state_d;
    logic [VIS_DIM-1:0]   v_q, v_d;
    logic [HID_DIM-1:0]   h_q, h_d;
    logic [STEP_W-1:0]    k_q, k_d;
    logic [STEP_W-1:0]    step_q, step_d;
    logic [HID_DIM-1:0]   h0_q, h0_d;
    logic [VIS_DIM-1:0]   vk_q, vk_d;
    logic [HID_DIM-1:0]   hk_q, hk_d;
    logic                 last_vh_q, last_vh_d;
    logic                 err_q, err_d;
    logic                 timeout_hit;

`ifdef GIBBS_WATCHDOG_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wd_q, wd_d;

    assign timeout_hit = (wd_q == WD_W'(TIMEOUT - 1));

    always_comb begin
        wd_d = wd_q;
        if (state_q == StClrVh || state_q == StClrHv) begin
            wd_d = '0;
        end else if (state_q == StRunVh || state_q == StRunHv) begin
            wd_d = wd_q + WD_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end

    assign err = err_q;
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT;
    assign timeout_hit    = 1'b0;
    assign err            = 1'b0;
`endif

    // Result bits above both dimensions never carry a sample.
    if (MAX_DIM > USED_DIM) begin : g_unused_result
        logic unused_result;
        assign unused_result = ^eng_result[MAX_DIM-1:USED_DIM];
    end

    always_comb begin
        state_d   = state_q;
        v_d       = v_q;
        h_d       = h_q;
        k_d       = k_q;
        step_d    = step_q;
        h0_d      = h0_q;
        vk_d      = vk_q;
        hk_d      = hk_q;
        last_vh_d = last_vh_q;
        err_d     = err_q;
        eng_reset = 1'b0;
        eng_dir   = 1'b0;
        eng_valid = 1'b0;
        eng_in    = '0;
        busy      = 1'b0;
        done      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    v_d       = vis_in;
                    k_d       = num_steps;
                    step_d    = '0;
                    last_vh_d = 1'b0;
                    err_d     = 1'b0;
                    if (num_steps == '0) begin
                        vk_d    = vis_in;
                        h0_d    = '0;
                        hk_d    = '0;
                        state_d = StFin;
                    end else begin
                        state_d = StClrVh;
                    end
                end
            end
            StClrVh: begin
                busy      = 1'b1;
                eng_reset = 1'b1;
                eng_in    = MAX_DIM'(v_q);
                state_d   = StRunVh;
            end
            StRunVh: begin
                busy      = 1'b1;
                eng_valid = 1'b1;
                eng_in    = MAX_DIM'(v_q);
                if (eng_finish) begin
                    h_d = eng_result[HID_DIM-1:0];
                    if (step_q == '0) begin
                        h0_d = eng_result[HID_DIM-1:0];
                    end
                    if (last_vh_q) begin
                        hk_d    = eng_result[HID_DIM-1:0];
                        vk_d    = v_q;
                        state_d = StFin;
                    end else begin
                        state_d = StClrHv;
                    end
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end
            end
            StClrHv: begin
                busy      = 1'b1;
                eng_reset = 1'b1;
                eng_dir   = 1'b1;
                eng_in    = MAX_DIM'(h_q);
                state_d   = StRunHv;
            end
            StRunHv: begin
                busy      = 1'b1;
                eng_dir   = 1'b1;
                eng_valid = 1'b1;
                eng_in    = MAX_DIM'(h_q);
                if (eng_finish) begin
                    v_d = eng_result[VIS_DIM-1:0];
                    if (step_q != '1) begin
                        step_d = step_q + STEP_W'(1);
                    end
                    if (({1'b0, step_q} + (STEP_W + 1)'(1)) == {1'b0, k_q}) begin
                        last_vh_d = 1'b1;
                    end
                    state_d = StClrVh;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end
            end
            StFin: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Abort beats any same-cycle capture: every register holds.
        if (abort && state_q != StIdle) begin
            state_d   = StIdle;
            v_d       = v_q;
            h_d       = h_q;
            k_d       = k_q;
            step_d    = step_q;
            h0_d      = h0_q;
            vk_d      = vk_q;
            hk_d      = hk_q;
            last_vh_d = last_vh_q;
            err_d     = err_q;
            done      = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            v_q       <= '0;
            h_q       <= '0;
            k_q       <= '0;
            step_q    <= '0;
            h0_q      <= '0;
            vk_q      <= '0;
            hk_q      <= '0;
            last_vh_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            v_q       <= v_d;
            h_q       <= h_d;
            k_q       <= k_d;
            step_q    <= step_d;
            h0_q      <= h0_d;
            vk_q      <= vk_d;
            hk_q      <= hk_d;
            last_vh_q <= last_vh_d;
            err_q     <= err_d;
        end
    end

    assign h0_out     = h0_q;
    assign vk_out     = vk_q;
    assign hk_out     = hk_q;
    assign step_count = step_q;

endmodule

// File: tb/tb_rbm_gibbs_sequencer.sv
// Directed bench for rbm_gibbs_sequencer with a fixed-latency engine model.
module tb_rbm_gibbs_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  num_steps;
    logic        abort;
    logic [14:0] vis_in;
    logic        eng_reset;
    logic        eng_dir;
    logic        eng_valid;
    logic [14:0] eng_in;
    logic        eng_finish;
    logic [14:0] eng_result;
    logic [4:0]  h0_out;
    logic [14:0] vk_out;
    logic [4:0]  hk_out;
    logic [7:0]  step_count;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    rbm_gibbs_sequencer #(
        .VIS_DIM(15),
        .HID_DIM(5),
        .MAX_DIM(15),
        .STEP_W (8),
        .TIMEOUT(16)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .num_steps (num_steps),
        .abort     (abort),
        .vis_in    (vis_in),
        .eng_reset (eng_reset),
        .eng_dir   (eng_dir),
        .eng_valid (eng_valid),
        .eng_in    (eng_in),
        .eng_finish(eng_finish),
        .eng_result(eng_result),
        .h0_out    (h0_out),
        .vk_out    (vk_out),
        .hk_out    (hk_out),
        .step_count(step_count),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clock = ~clock;

    // Engine model: finish level rises after lat valid cycles, stays until the next clear.
    int          lat = 3;
    int          cnt = 0;
    int          pass_idx = 0;
    int          pass_base = 0;
    logic [14:0] res_tab [0:15];

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= 0;
        end else if (eng_reset) begin
            cnt      <= 0;
            pass_idx <= pass_idx + 1;
        end else if (eng_valid && lat > 0 && cnt < lat - 1) begin
            cnt <= cnt + 1;
        end
    end

    assign eng_finish = (lat > 0) && (cnt == lat - 1);

    always_comb begin
        eng_result = '0;
        if (pass_idx > pass_base && pass_idx - pass_base <= 16) begin
            eng_result = res_tab[pass_idx - pass_base - 1];
        end
    end

    int          rst_cnt = 0;
    int          done_cnt = 0;
    logic        dir_log [0:63];
    logic [14:0] ein_log [0:63];

    always @(negedge clock) begin
        if (eng_reset === 1'b1) begin
            dir_log[rst_cnt] = eng_dir;
            ein_log[rst_cnt] = eng_in;
            rst_cnt++;
        end
        if (done === 1'b1) done_cnt++;
    end

    task automatic launch(input logic [7:0] k, input logic [14:0] v);
        num_steps = k;
        vis_in    = v;
        start     = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic run_to_done(input int c0, output int cyc);
        cyc = c0;
        while (done !== 1'b1 && cyc < 200) begin
            @(posedge clock);
            #1;
            cyc++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        num_steps = '0;
        vis_in = '0;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if ({h0_out, vk_out, hk_out, step_count, busy, done, err, eng_reset, eng_dir, eng_valid,
             eng_in} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got h0=%h vk=%h hk=%h step=%0d busy=%b done=%b exp all 0",
                     h0_out, vk_out, hk_out, step_count, busy, done);
        end
        reset = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic test_k0;
        int rb, db;
        rb = rst_cnt;
        db = done_cnt;
        launch(8'd0, 15'h1234);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL k0_done got done=%b busy=%b exp done=1 busy=0", done, busy);
        end
        checks++;
        if (vk_out !== 15'h1234 || h0_out !== 5'h00 || hk_out !== 5'h00) begin
            errors++;
            $display("FAIL k0_results got vk=%h h0=%h hk=%h exp 1234 00 00",
                     vk_out, h0_out, hk_out);
        end
        @(posedge clock);
        #1;
        checks++;
        if (done !== 1'b0 || done_cnt - db != 1 || rst_cnt != rb) begin
            errors++;
            $display("FAIL k0_pulses got done=%b dones=%0d clears=%0d exp 0 1 0",
                     done, done_cnt - db, rst_cnt - rb);
        end
    endtask

    task automatic test_k1;
        int rb, cyc;
        logic [2:0] dirs;
        lat = 3;
        res_tab[0] = 15'h0015;
        res_tab[1] = 15'h7001;
        res_tab[2] = 15'h000A;
        pass_base = pass_idx;
        rb = rst_cnt;
        launch(8'd1, 15'h2AAA);
        checks++;
        if (busy !== 1'b1 || eng_reset !== 1'b1 || eng_dir !== 1'b0 || eng_in !== 15'h2AAA) begin
            errors++;
            $display("FAIL k1_first_clear got busy=%b rst=%b dir=%b in=%h exp 1 1 0 2aaa",
                     busy, eng_reset, eng_dir, eng_in);
        end
        run_to_done(1, cyc);
        checks++;
        if (cyc != 13) begin
            errors++;
            $display("FAIL k1_latency got %0d exp 13", cyc);
        end
        checks++;
        if (h0_out !== 5'h15 || vk_out !== 15'h7001 || hk_out !== 5'h0A || step_count !== 8'd1) begin
            errors++;
            $display("FAIL k1_results got h0=%h vk=%h hk=%h step=%0d exp 15 7001 0a 1",
                     h0_out, vk_out, hk_out, step_count);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL k1_busy_at_done got %b exp 0", busy);
        end
        dirs = {dir_log[rb], dir_log[rb + 1], dir_log[rb + 2]};
        checks++;
        if (rst_cnt - rb != 3 || dirs !== 3'b010) begin
            errors++;
            $display("FAIL k1_passes got clears=%0d dirs=%b exp 3 010", rst_cnt - rb, dirs);
        end
        checks++;
        if (ein_log[rb + 1] !== 15'h0015 || ein_log[rb + 2] !== 15'h7001) begin
            errors++;
            $display("FAIL k1_eng_in got %h %h exp 0015 7001", ein_log[rb + 1], ein_log[rb + 2]);
        end
        @(posedge clock);
        #1;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL k1_done_width got %b exp 0", done);
        end
    endtask

    task automatic test_back_to_back;
        int rb, db, cyc;
        logic [6:0] dirs;
        res_tab[0] = 15'h0003;
        res_tab[1] = 15'h0111;
        res_tab[2] = 15'h0007;
        res_tab[3] = 15'h0222;
        res_tab[4] = 15'h001F;
        res_tab[5] = 15'h0333;
        res_tab[6] = 15'h0011;
        pass_base = pass_idx;
        rb = rst_cnt;
        db = done_cnt;
        launch(8'd3, 15'h0F0F);
        repeat (4) begin
            @(posedge clock);
            #1;
        end
        num_steps = 8'd0;
        vis_in = 15'h7FFF;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        run_to_done(6, cyc);
        checks++;
        if (cyc != 29) begin
            errors++;
            $display("FAIL k3_latency got %0d exp 29", cyc);
        end
        checks++;
        if (h0_out !== 5'h03 || vk_out !== 15'h0333 || hk_out !== 5'h11 || step_count !== 8'd3) begin
            errors++;
            $display("FAIL k3_results got h0=%h vk=%h hk=%h step=%0d exp 03 0333 11 3",
                     h0_out, vk_out, hk_out, step_count);
        end
        for (int i = 0; i < 7; i++) dirs[6 - i] = dir_log[rb + i];
        checks++;
        if (rst_cnt - rb != 7 || dirs !== 7'b0101010) begin
            errors++;
            $display("FAIL k3_passes got clears=%0d dirs=%b exp 7 0101010", rst_cnt - rb, dirs);
        end
        checks++;
        if (ein_log[rb] !== 15'h0F0F || ein_log[rb + 3] !== 15'h0007) begin
            errors++;
            $display("FAIL k3_eng_in got %h %h exp 0f0f 0007", ein_log[rb], ein_log[rb + 3]);
        end
        @(posedge clock);
        #1;
        checks++;
        if (done_cnt - db != 1) begin
            errors++;
            $display("FAIL k3_done_count got %0d exp 1", done_cnt - db);
        end
    endtask

    task automatic test_abort;
        int rb, db;
        res_tab[0] = 15'h000C;
        res_tab[1] = 15'h1111;
        res_tab[2] = 15'h0004;
        pass_base = pass_idx;
        rb = rst_cnt;
        db = done_cnt;
        launch(8'd2, 15'h0005);
        repeat (7) begin
            @(posedge clock);
            #1;
        end
        checks++;
        if (eng_valid !== 1'b1 || eng_dir !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre got valid=%b dir=%b busy=%b exp 1 1 1",
                     eng_valid, eng_dir, busy);
        end
        abort = 1'b1;
        @(posedge clock);
        #1;
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || eng_valid !== 1'b0 || done !== 1'b0 || step_count !== 8'd0) begin
            errors++;
            $display("FAIL abort_state got busy=%b valid=%b done=%b step=%0d exp 0 0 0 0",
                     busy, eng_valid, done, step_count);
        end
        checks++;
        if (h0_out !== 5'h0C || vk_out !== 15'h0333 || hk_out !== 5'h11) begin
            errors++;
            $display("FAIL abort_hold got h0=%h vk=%h hk=%h exp 0c 0333 11", h0_out, vk_out, hk_out);
        end
        repeat (5) @(posedge clock);
        #1;
        checks++;
        if (done_cnt != db || rst_cnt - rb != 2 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_quiet got dones=%0d clears=%0d busy=%b exp 0 2 0",
                     done_cnt - db, rst_cnt - rb, busy);
        end
    endtask

    task automatic test_reset_mid;
        int cyc;
        res_tab[0] = 15'h0001;
        res_tab[1] = 15'h0002;
        res_tab[2] = 15'h0003;
        pass_base = pass_idx;
        launch(8'd1, 15'h0100);
        repeat (5) begin
            @(posedge clock);
            #1;
        end
        checks++;
        if (eng_dir !== 1'b1 || eng_valid !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre got dir=%b valid=%b exp 1 1", eng_dir, eng_valid);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({h0_out, vk_out, hk_out, step_count, busy, done, err, eng_reset, eng_valid,
             eng_in} !== '0) begin
            errors++;
            $display("FAIL rstmid_outputs got h0=%h vk=%h hk=%h step=%0d busy=%b valid=%b exp 0",
                     h0_out, vk_out, hk_out, step_count, busy, eng_valid);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
        res_tab[0] = 15'h001E;
        res_tab[1] = 15'h4321;
        res_tab[2] = 15'h0005;
        pass_base = pass_idx;
        launch(8'd1, 15'h0001);
        run_to_done(1, cyc);
        checks++;
        if (cyc != 13 || h0_out !== 5'h1E || vk_out !== 15'h4321 || hk_out !== 5'h05 ||
            step_count !== 8'd1) begin
            errors++;
            $display("FAIL rstmid_rerun got cyc=%0d h0=%h vk=%h hk=%h step=%0d exp 13 1e 4321 05 1",
                     cyc, h0_out, vk_out, hk_out, step_count);
        end
        @(posedge clock);
        #1;
    endtask

`ifdef GIBBS_WATCHDOG_EN
    task automatic test_watchdog;
        int db;
        db = done_cnt;
        lat = 0;
        launch(8'd1, 15'h0003);
        repeat (16) begin
            @(posedge clock);
            #1;
        end
        checks++;
        if (eng_valid !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL wd_pre got valid=%b err=%b exp 1 0", eng_valid, err);
        end
        @(posedge clock);
        #1;
        checks++;
        if (err !== 1'b1 || eng_valid !== 1'b0 || busy !== 1'b0 || done_cnt != db) begin
            errors++;
            $display("FAIL wd_trip got err=%b valid=%b busy=%b dones=%0d exp 1 0 0 0",
                     err, eng_valid, busy, done_cnt - db);
        end
        lat = 3;
        launch(8'd0, 15'h0000);
        checks++;
        if (err !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL wd_clear got err=%b done=%b exp 0 1", err, done);
        end
        @(posedge clock);
        #1;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL global_timeout got no finish exp finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_k0();
        test_k1();
        test_back_to_back();
        test_abort();
        test_reset_mid();
`ifdef GIBBS_WATCHDOG_EN
        test_watchdog();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
